// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port backend memory between the instruction-fetch port
//   (if_*) and the data-memory port (dm_*). One backend transaction is in
//   flight at a time. Data requests win arbitration, but a starvation counter
//   forces a fetch grant after STARVE_MAX consecutive data grants taken while
//   a fetch was waiting. A timeout completes a transaction with bus_err when
//   the backend never answers.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   if_req/if_addr             fetch request, held stable until if_done
//   if_rdata/if_done           fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/      data request, held stable until dm_done
//   dm_wdata
//   dm_rdata/dm_done           data read data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/   backend request, held until mem_gnt
//   mem_wdata/mem_gnt
//   mem_rvalid/mem_rdata       backend response (reads and writes)
//   bus_err                    pulses with *_done when the transaction timed out
//   stall                      pipeline stall while any requester waits
//   dbg_state                  current FSM state, for observation only
//
// Handshakes
//   Requester side: *_req is raised with its payload and held stable until the
//   matching *_done pulse; the requester may drop or change it on the edge
//   that ends the done cycle. Backend side: mem_req with payload is held until
//   the cycle mem_gnt is high (that cycle is the transfer); afterwards exactly
//   one mem_rvalid is expected, which ends the transaction.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          owner_dm, owner_dm_nxt;   // 1: data port owns the transaction
  logic [SW-1:0] starve, starve_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          err, err_nxt;
  logic [31:0]   if_rdata_nxt, dm_rdata_nxt;
  logic          pick_dm;
  logic          other_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner_dm <= 1'b0;
      starve   <= '0;
      tmo      <= '0;
      err      <= 1'b0;
      if_rdata <= 32'h0;
      dm_rdata <= 32'h0;
    end else begin
      state    <= state_nxt;
      owner_dm <= owner_dm_nxt;
      starve   <= starve_nxt;
      tmo      <= tmo_nxt;
      err      <= err_nxt;
      if_rdata <= if_rdata_nxt;
      dm_rdata <= dm_rdata_nxt;
    end
  end

  // Data wins unless a fetch is waiting and has already been passed over
  // STARVE_MAX times in a row.
  assign pick_dm = dm_req & ~(if_req & (starve == STARVE_TOP));

  always_comb begin
    state_nxt    = state;
    owner_dm_nxt = owner_dm;
    starve_nxt   = starve;
    tmo_nxt      = tmo;
    err_nxt      = err;
    if_rdata_nxt = if_rdata;
    dm_rdata_nxt = dm_rdata;
    case (state)
      IDLE: begin
        if (if_req | dm_req) begin
          owner_dm_nxt = pick_dm;
          err_nxt      = 1'b0;
          state_nxt    = REQ;
          if (pick_dm & if_req) begin
            starve_nxt = (starve == STARVE_TOP) ? starve : starve + SW'(1);
          end else begin
            starve_nxt = '0;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          tmo_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        tmo_nxt = tmo + TW'(1);
        // A response on the final timeout cycle still counts as a good one.
        if (mem_rvalid) begin
          if (!owner_dm) begin
            if_rdata_nxt = mem_rdata;
          end else if (!dm_we) begin
            dm_rdata_nxt = mem_rdata;
          end
          state_nxt = DONE;
        end else if (tmo == TMO_LAST) begin
          if (!owner_dm) begin
            if_rdata_nxt = 32'h0;
          end else if (!dm_we) begin
            dm_rdata_nxt = 32'h0;
          end
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Backend payload follows the live requester inputs while in REQ; the
  // requester guarantees they are stable, so no copy is registered.
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & owner_dm & dm_we;
  assign mem_addr  = !mem_req ? 32'h0 : (owner_dm ? dm_addr : if_addr);
  assign mem_wdata = (mem_req & owner_dm) ? dm_wdata : 32'h0;

  assign if_done = (state == DONE) & ~owner_dm;
  assign dm_done = (state == DONE) & owner_dm;
  assign bus_err = (state == DONE) & err;

  // In DONE the owner is being released this cycle, so it only keeps the
  // pipeline stalled if the other port is also waiting.
  assign other_req = owner_dm ? if_req : dm_req;
  assign stall     = (if_req | dm_req) & ~((state == DONE) & ~other_req);

  assign dbg_state = state;

endmodule
